// File: rtl/rv_uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv_uart_pkg
// Description : Shared types and elaboration-time helpers for the UART
//               instruction-memory loader.
//                 rx_state_t - serial receiver FSM states
//                 div_ratio  - clocks per oversample tick, rounded to nearest
//                 cnt_width  - bits needed to count from 0 up to max_val
// Revision    : 1.0 - initial release
// ============================================================================
package rv_uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_WAIT_HI = 3'd4
  } rx_state_t;

  function automatic int div_ratio(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 serial receiver: 2-flop rx synchroniser, oversample tick
//               divider and receive FSM.
// Ports       : clk        - system clock
//               Rst_n      - asynchronous active-low reset
//               rx         - asynchronous serial input, idle high
//               enable     - receiver enable; low forces the FSM to idle
//               tick       - oversample tick strobe (free-running)
//               idle       - FSM is in RX_IDLE
//               byte_valid - one-cycle pulse in the stop-bit sample cycle
//               byte_data  - received byte, valid with byte_valid
//               frame_err  - one-cycle pulse when the stop bit reads low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import rv_uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic       rx,
  input  logic       enable,
  output logic       tick,
  output logic       idle,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int DIV  = div_ratio(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = cnt_width(DIV - 1);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DIV_W-1:0] div_cnt_q;
  rx_state_t        state_q, state_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             start_det;

  // Falling edge of the synchronised line while idle marks a start bit.
  assign start_det = enable && (state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;
  assign tick      = (div_cnt_q == DIV_LAST);
  assign idle      = (state_q == RX_IDLE);
  assign byte_data = shift_q;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      div_cnt_q <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      // Restarting on the start edge phase-aligns ticks to the incoming frame.
      if (start_det || tick) div_cnt_q <= '0;
      else                   div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= RX_IDLE;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (start_det) begin
          state_d  = RX_START;
          os_cnt_d = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (os_cnt_q == OS_HALF) begin
            // Middle of the start bit: from here every OVERSAMPLE ticks is mid-bit.
            os_cnt_d  = '0;
            bit_idx_d = '0;
            state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
          if (os_cnt_q == OS_LAST) begin
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
          if (os_cnt_q == OS_LAST) begin
            if (rx_sync_q) begin
              byte_valid = 1'b1;
              state_d    = RX_IDLE;
            end else begin
              frame_err = 1'b1;
              state_d   = RX_WAIT_HI;
            end
          end
        end
      end
      RX_WAIT_HI: begin
        if (rx_sync_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
    if (!enable) begin
      state_d    = RX_IDLE;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_imem_loader
// Description : UART program loader feeding the core's instruction memory.
//               Packs received bytes little-endian into 32-bit words and
//               writes them to consecutive word addresses while prog is high.
//               Optional feature macro: LOADER_CHECKSUM_EN (running word sum
//               on checksum; when undefined checksum is tied to zero).
// Ports       : clk, Rst_n          - clock, asynchronous active-low reset
//               rx                  - UART receive pin, idle high
//               prog                - loader enable, rising edge restarts image
//               imem_prog_ena/en    - one-cycle write strobe per word
//               imem_addr/imem_din  - word address and data of the write
//               busy                - byte in flight or partial word held
//               word_count          - words written since prog rose, saturating
//               err_frame           - sticky stop-bit error
//               checksum            - running sum of written words
// Revision    : 1.0 - initial release
// ============================================================================
module uart_imem_loader
  import rv_uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int ADDR_W       = 10,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              rx,
  input  logic              prog,
  output logic              imem_prog_ena,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              err_frame,
  output logic [31:0]       checksum
);

  localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = cnt_width(TO_TICKS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TICKS - 1);

  logic              tick, rx_idle, byte_valid, frame_err;
  logic [7:0]        byte_data;
  logic              prog_q, wr_q, err_q;
  logic [1:0]        k_q;
  logic [31:0]       din_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   wc_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              prog_rise, timeout_hit;

  uart_rx_core #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx (
    .clk        (clk),
    .Rst_n      (Rst_n),
    .rx         (rx),
    .enable     (prog),
    .tick       (tick),
    .idle       (rx_idle),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign prog_rise   = prog && !prog_q;
  assign timeout_hit = (k_q != 2'd0) && rx_idle && tick && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prog_q   <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      k_q      <= '0;
      din_q    <= '0;
      addr_q   <= '0;
      wc_q     <= '0;
      to_cnt_q <= '0;
    end else begin
      prog_q <= prog;
      wr_q   <= 1'b0;
      if (prog_rise) begin
        addr_q   <= '0;
        wc_q     <= '0;
        err_q    <= 1'b0;
        k_q      <= '0;
        to_cnt_q <= '0;
      end else begin
        // Address advances only after the strobe so it is stable during the write.
        if (wr_q) begin
          addr_q <= addr_q + 1'b1;
          if (wc_q != '1) wc_q <= wc_q + 1'b1;
        end
        if (frame_err) err_q <= 1'b1;
        if (!prog) begin
          k_q <= '0;
        end else if (byte_valid) begin
          din_q[{k_q, 3'b000} +: 8] <= byte_data;
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) wr_q <= 1'b1;
        end else if (timeout_hit) begin
          k_q <= '0;
        end
        // Idle-time counter runs only while a partial word waits for more bytes.
        if ((k_q == 2'd0) || !rx_idle) to_cnt_q <= '0;
        else if (tick)                 to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  assign imem_prog_ena = wr_q;
  assign imem_en       = wr_q;
  assign imem_addr     = addr_q;
  assign imem_din      = din_q;
  assign word_count    = wc_q;
  assign err_frame     = err_q;
  assign busy          = !rx_idle || (k_q != 2'd0);

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cks_q;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n)         cks_q <= '0;
    else if (prog_rise) cks_q <= '0;
    else if (wr_q)      cks_q <= cks_q + din_q;
  end

  assign checksum = cks_q;
`else
  assign checksum = 32'h0;
`endif

endmodule
`default_nettype wire
